clock_time_keeper: RTL and testbench
====================================

Name: clock_time_keeper

Overview:
- Downstream consumer of the 0.1 s prescaler counter (32-bit counter wrapping at 4_999_999 on a 50 MHz clock).
- Takes the prescaler's one-cycle wrap pulse and keeps 24-hour time of day (HH:MM:SS.t) in BCD.
- Provides a two-button set interface (mode/increment) and a blink flag for the display driver.

Parameters:
- TICKS_PER_SEC, 10: i_tick pulses per second; the tenths digit wraps at TICKS_PER_SEC-1.
- BLINK_TICKS, 5: i_tick pulses per blink half-period in set states.

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_tick  in  1  single-cycle pulse, one per 0.1 s, from the prescaler wrap
- i_mode  in  1  debounced single-cycle pulse; advances set state
- i_inc  in  1  debounced single-cycle pulse; increments the selected field
- o_hour_bcd  out  8  hours, BCD 00-23
- o_min_bcd  out  8  minutes, BCD 00-59
- o_sec_bcd  out  8  seconds, BCD 00-59
- o_tenth  out  4  tenths, binary 0-9
- o_state  out  2  0=RUN, 1=SET_HR, 2=SET_MIN
- o_blink  out  1  1 = blank the selected field
- o_sec_pulse  out  1  one-cycle pulse when seconds advance

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rstn.
- Reset values: all time fields 0, state RUN, o_blink 0, o_sec_pulse 0, blink counter 0.
- Timing: all outputs are registered. An event sampled at edge N is visible after edge N.
- RUN state:
  - On i_tick, tenths increments.
  - When tenths is 9, tenths goes to 0, seconds increments, and o_sec_pulse is 1 for that cycle.
  - Carries ripple in the same cycle: sec 59->00 increments min; min 59->00 increments hour; hour 23->00.
  - 23:59:59.9 plus one tick gives 00:00:00.0.
  - i_inc is ignored.
- State transitions on i_mode: RUN->SET_HR->SET_MIN->RUN. No other transitions.
- Set states (SET_HR, SET_MIN):
  - Time is frozen; i_tick drives only the blink counter.
  - o_sec_pulse stays 0.
- SET_HR, i_inc: hour = (hour+1) mod 24 in BCD (09->10, 19->20, 23->00). Minutes are unaffected.
- SET_MIN, i_inc: min = (min+1) mod 60 in BCD (59->00), with no carry into hours.
- Blink:
  - In set states, the blink counter counts i_tick pulses. On reaching BLINK_TICKS it clears and o_blink toggles.
  - Entering SET_HR from RUN clears the blink counter and o_blink.
  - Moving SET_HR->SET_MIN also clears the blink counter and o_blink.
  - In RUN, o_blink is held 0.
- Leaving SET_MIN for RUN: sec=00, tenth=0, blink counter=0, o_blink=0. Counting resumes on the next i_tick.
- Simultaneous events:
  - i_mode and i_inc together: the mode transition happens and i_inc is dropped.
  - i_mode and i_tick in RUN: the tick is applied, then the state advances.
  - i_mode and i_tick in SET_MIN: the exit clear wins (tenth=0).
- Reset mid-operation: immediate return to reset values regardless of state. No partial increment survives.
- Inputs are guaranteed single-cycle and synchronous to i_clk. No edge detection is done here.

Decomposition:
- Shared package `clock_pkg`:
  - State encoding constants ST_RUN=2'd0, ST_SET_HR=2'd1, ST_SET_MIN=2'd2.
  - BCD limits HOUR_MAX=8'h23, MIN_MAX=8'h59, SEC_MAX=8'h59.
- Sub-module `bcd2_mod_counter`:
  - Two-digit BCD counter with parameter MAX_BCD.
  - Inputs: inc, clr. Output: carry (inc while at MAX_BCD).
  - Instantiated three times: seconds, minutes, hours.
- Tenths counter, blink counter and FSM live in the top level.

Test Plan:
1. Reset, then 10 i_tick pulses spaced 20 cycles apart -> o_sec_bcd=8'h01, o_tenth=0; exactly one o_sec_pulse, coincident with sec 00->01.
2. Set hour 23 and minute 59 via SET_HR/SET_MIN, return to RUN, apply 599 ticks -> 23:59:59.9; one more tick -> 00:00:00.0 and one o_sec_pulse.
3. SET_HR, 24 i_inc pulses from 00 -> sequence passes 09->10 and 19->20, ends at 8'h00; o_min_bcd unchanged throughout.
4. SET_MIN at 8'h59, i_mode and i_inc in the same cycle -> state RUN, minutes still 8'h59, sec=00, tenth=0.
5. SET_MIN with 12 i_tick pulses -> o_blink rises after tick 5, falls after tick 10; o_tenth and o_sec_bcd frozen; o_sec_pulse never asserts.
6. i_rstn low asynchronously mid-SET_HR between clock edges -> all outputs 0 and o_state=0 before the next edge; normal counting after release.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day keeper: FSM encoding and BCD field limits.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;

endpackage

// File: rtl/clock_time_keeper_bcd2.sv
// Two-digit BCD counter that wraps to 00 after MAX_BCD; carry_c flags that wrap.
module bcd2_mod_counter #(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry_c
);

  // Wrap indication is combinational so the next field can advance in the same cycle.
  assign carry_c = inc && (value == MAX_BCD);

  // BCD increment with wrap at MAX_BCD; clear has priority.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      value <= 8'h00;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      if (value == MAX_BCD) begin
        value <= 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value <= {value[7:4] + 4'd1, 4'd0};
      end else begin
        value <= {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// 24-hour BCD time-of-day keeper driven by a 0.1 s tick, with a two-button set mode.
import clock_pkg::*;

module clock_time_keeper #(
  parameter int unsigned TICKS_PER_SEC = 10,
  parameter int unsigned BLINK_TICKS   = 5
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_tick,
  input  logic       i_mode,
  input  logic       i_inc,
  output logic [7:0] o_hour_bcd,
  output logic [7:0] o_min_bcd,
  output logic [7:0] o_sec_bcd,
  output logic [3:0] o_tenth,
  output logic [1:0] o_state,
  output logic       o_blink,
  output logic       o_sec_pulse
);

  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [3:0] TENTH_LAST = 4'(TICKS_PER_SEC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  state_t             state;
  logic [3:0]         tenth;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink;
  logic               sec_pulse;

  logic in_run_c;
  logic in_hr_c;
  logic in_min_c;
  logic tenth_wrap_c;
  logic exit_set_c;
  logic sec_inc_c;
  logic min_inc_c;
  logic hour_inc_c;
  logic sec_carry_c;
  logic min_carry_c;
  logic unused_hour_wrap_c;

  // Event decode; a mode press always swallows a simultaneous increment.
  assign in_run_c     = (state == ST_RUN);
  assign in_hr_c      = (state == ST_SET_HR);
  assign in_min_c     = (state == ST_SET_MIN);
  assign tenth_wrap_c = in_run_c && i_tick && (tenth == TENTH_LAST);
  assign exit_set_c   = in_min_c && i_mode;
  assign sec_inc_c    = tenth_wrap_c;
  assign min_inc_c    = (in_run_c && sec_carry_c) || (in_min_c && i_inc && !i_mode);
  assign hour_inc_c   = (in_run_c && min_carry_c) || (in_hr_c && i_inc && !i_mode);

  bcd2_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .inc     (sec_inc_c),
    .clr     (exit_set_c),
    .value   (o_sec_bcd),
    .carry_c (sec_carry_c)
  );

  bcd2_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .inc     (min_inc_c),
    .clr     (1'b0),
    .value   (o_min_bcd),
    .carry_c (min_carry_c)
  );

  bcd2_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hour (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .inc     (hour_inc_c),
    .clr     (1'b0),
    .value   (o_hour_bcd),
    .carry_c (unused_hour_wrap_c)
  );

  // Tenths digit and the seconds-advance pulse; leaving set mode restarts the second.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tenth     <= 4'd0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= tenth_wrap_c;
      if (exit_set_c) begin
        tenth <= 4'd0;
      end else if (in_run_c && i_tick) begin
        tenth <= tenth_wrap_c ? 4'd0 : tenth + 4'd1;
      end
    end
  end

  // Mode FSM plus the blink half-period counter that only runs in set states.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= ST_RUN;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          blink_cnt <= '0;
          blink     <= 1'b0;
          if (i_mode) state <= ST_SET_HR;
        end
        ST_SET_HR, ST_SET_MIN: begin
          if (i_mode) begin
            state     <= in_hr_c ? ST_SET_MIN : ST_RUN;
            blink_cnt <= '0;
            blink     <= 1'b0;
          end else if (i_tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blink     <= ~blink;
            end else begin
              blink_cnt <= blink_cnt + BLINK_W'(1);
            end
          end
        end
        default: begin
          state     <= ST_RUN;
          blink_cnt <= '0;
          blink     <= 1'b0;
        end
      endcase
    end
  end

  assign o_tenth     = tenth;
  assign o_state     = state;
  assign o_blink     = blink;
  assign o_sec_pulse = sec_pulse;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Randomised and directed bench for clock_time_keeper against a time-of-day model.
module tb_clock_time_keeper;

  logic       i_clk  = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_mode = 1'b0;
  logic       i_inc  = 1'b0;
  logic [7:0] o_hour_bcd;
  logic [7:0] o_min_bcd;
  logic [7:0] o_sec_bcd;
  logic [3:0] o_tenth;
  logic [1:0] o_state;
  logic       o_blink;
  logic       o_sec_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  // Model: plain integer time of day and mode.
  int m_h, m_m, m_s, m_t, m_st, m_cnt;
  bit m_blink, m_pulse;

  always #5 i_clk = ~i_clk;

  clock_time_keeper #(.TICKS_PER_SEC(10), .BLINK_TICKS(5)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_tick      (i_tick),
    .i_mode      (i_mode),
    .i_inc       (i_inc),
    .o_hour_bcd  (o_hour_bcd),
    .o_min_bcd   (o_min_bcd),
    .o_sec_bcd   (o_sec_bcd),
    .o_tenth     (o_tenth),
    .o_state     (o_state),
    .o_blink     (o_blink),
    .o_sec_pulse (o_sec_pulse)
  );

  function automatic logic [31:0] bcd(int v);
    return 32'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference behaviour, one update per clock edge.
  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m_h = 0; m_m = 0; m_s = 0; m_t = 0; m_st = 0; m_cnt = 0;
      m_blink = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_st == 0) begin
        if (i_tick) begin
          m_t++;
          if (m_t == 10) begin
            m_t = 0;
            m_pulse = 1;
            m_s++;
            if (m_s == 60) begin
              m_s = 0;
              m_m++;
              if (m_m == 60) begin
                m_m = 0;
                m_h = (m_h + 1) % 24;
              end
            end
          end
        end
        if (i_mode) begin
          m_st = 1; m_cnt = 0; m_blink = 0;
        end
      end else if (i_mode) begin
        if (m_st == 2) begin
          m_s = 0; m_t = 0; m_st = 0;
        end else begin
          m_st = 2;
        end
        m_cnt = 0; m_blink = 0;
      end else begin
        if (i_inc && m_st == 1) m_h = (m_h + 1) % 24;
        if (i_inc && m_st == 2) m_m = (m_m + 1) % 60;
        if (i_tick) begin
          m_cnt++;
          if (m_cnt == 5) begin
            m_cnt = 0;
            m_blink = !m_blink;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("hour",  32'(o_hour_bcd),  bcd(m_h));
      chk("min",   32'(o_min_bcd),   bcd(m_m));
      chk("sec",   32'(o_sec_bcd),   bcd(m_s));
      chk("tenth", 32'(o_tenth),     32'(m_t));
      chk("state", 32'(o_state),     32'(m_st));
      chk("blink", 32'(o_blink),     32'(m_blink));
      chk("pulse", 32'(o_sec_pulse), 32'(m_pulse));
    end
    if (o_sec_pulse === 1'b1) pulse_cnt++;
  end

  task automatic step(bit tk, bit md, bit ic);
    @(negedge i_clk);
    i_tick = tk; i_mode = md; i_inc = ic;
    @(posedge i_clk);
    #1;
    i_tick = 1'b0; i_mode = 1'b0; i_inc = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_hour", 32'(o_hour_bcd), 32'h00);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_blink", 32'(o_blink), 32'd0);

    // One second of ticks spaced 20 cycles apart.
    pulse_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0);
      repeat (19) step(0, 0, 0);
    end
    chk("t1_sec", 32'(o_sec_bcd), 32'h01);
    chk("t1_tenth", 32'(o_tenth), 32'd0);
    chk("t1_pulses", 32'(pulse_cnt), 32'd1);

    // Set 23:59, then roll over midnight.
    step(0, 1, 0);
    repeat (23) step(0, 0, 1);
    step(0, 1, 0);
    repeat (59) step(0, 0, 1);
    step(0, 1, 0);
    chk("t2_set_hour", 32'(o_hour_bcd), 32'h23);
    chk("t2_set_min", 32'(o_min_bcd), 32'h59);
    chk("t2_set_sec", 32'(o_sec_bcd), 32'h00);
    for (int k = 0; k < 599; k++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    chk("t2_pre_time", {8'h00, o_hour_bcd, o_min_bcd, o_sec_bcd}, 32'h00235959);
    chk("t2_pre_tenth", 32'(o_tenth), 32'd9);
    pulse_cnt = 0;
    step(1, 0, 0);
    chk("t2_midnight", {o_hour_bcd, o_min_bcd, o_sec_bcd, 4'h0, o_tenth}, 32'h0);
    step(0, 0, 0);
    chk("t2_pulses", 32'(pulse_cnt), 32'd1);

    // Run a little so the later exit clear has something to clear.
    repeat (37) step(1, 0, 0);

    // Full 24-step hour walk.
    step(0, 1, 0);
    for (int k = 1; k <= 24; k++) begin
      step(0, 0, 1);
      if (k == 9)  chk("t3_h09", 32'(o_hour_bcd), 32'h09);
      if (k == 10) chk("t3_h10", 32'(o_hour_bcd), 32'h10);
      if (k == 20) chk("t3_h20", 32'(o_hour_bcd), 32'h20);
    end
    chk("t3_h00", 32'(o_hour_bcd), 32'h00);
    chk("t3_min", 32'(o_min_bcd), 32'h00);

    // Minute to 59 then mode+inc together.
    step(0, 1, 0);
    repeat (59) step(0, 0, 1);
    chk("t4_pre_sec", 32'(o_sec_bcd), 32'h03);
    step(0, 1, 1);
    chk("t4_state", 32'(o_state), 32'd0);
    chk("t4_min", 32'(o_min_bcd), 32'h59);
    chk("t4_sec", 32'(o_sec_bcd), 32'h00);
    chk("t4_tenth", 32'(o_tenth), 32'd0);

    // Blink in SET_MIN.
    step(0, 1, 0);
    step(0, 1, 0);
    pulse_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1, 0, 0);
      if (k == 4)  chk("t5_blink4", 32'(o_blink), 32'd0);
      if (k == 5)  chk("t5_blink5", 32'(o_blink), 32'd1);
      if (k == 9)  chk("t5_blink9", 32'(o_blink), 32'd1);
      if (k == 10) chk("t5_blink10", 32'(o_blink), 32'd0);
    end
    chk("t5_frozen", {o_sec_bcd, 4'h0, o_tenth}, 32'h0);
    chk("t5_pulses", 32'(pulse_cnt), 32'd0);

    // Asynchronous reset in the middle of SET_HR.
    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (3) step(0, 0, 1);
    @(posedge i_clk);
    #3 i_rstn = 1'b0;
    #1;
    chk("t6_time", {o_hour_bcd, o_min_bcd, o_sec_bcd, 4'h0, o_tenth}, 32'h0);
    chk("t6_flags", {29'h0, o_state, o_blink}, 32'h0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (10) step(1, 0, 0);
    chk("t6_resume", 32'(o_sec_bcd), 32'h01);

    // Random traffic; the model compare runs every cycle.
    repeat (4000) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0);
    end

    @(negedge i_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
